// File: rtl/universal_shift_register.sv
// Universal shift register: parallel load, five shift/rotate modes, manual stepping
// and a counted burst engine with busy/done handshake.
module universal_shift_register #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] par_in,
   input  logic             ser_in,
   input  logic             shift_en,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic             abort,
   output logic [WIDTH-1:0] data_out,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   // Handshake: start is accepted only in IDLE; busy is high for exactly the N step
   // cycles of a burst, and done pulses for one IDLE cycle after the last step
   // (never after an abort or reset).
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] data_q, data_n;
   logic             ser_q, ser_n;
   logic [2:0]       mode_q, mode_n;
   logic [CNT_W-1:0] rem_q, rem_n;
   logic             done_q, done_n;

   // Result packed as {ser_out, data}; reserved modes hold both.
   function automatic logic [WIDTH:0] do_step(input logic [2:0] m, input logic [WIDTH-1:0] d,
                                              input logic s, input logic so);
      case (m)
         3'b000:  do_step = {d[WIDTH-1], d[WIDTH-2:0], s};
         3'b001:  do_step = {d[0], s, d[WIDTH-1:1]};
         3'b010:  do_step = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
         3'b011:  do_step = {d[0], d[0], d[WIDTH-1:1]};
         3'b100:  do_step = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
         default: do_step = {so, d};
      endcase
   endfunction

   always_comb begin
      state_n = state;
      data_n  = data_q;
      ser_n   = ser_q;
      mode_n  = mode_q;
      rem_n   = rem_q;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               data_n = par_in;
            end else if (start) begin
               mode_n = mode;
               rem_n  = count;
               if (count != '0) state_n = SHIFT;
               else             done_n  = 1'b1;
            end else if (shift_en) begin
               {ser_n, data_n} = do_step(mode, data_q, ser_in, ser_q);
            end
         end
         SHIFT: begin
            if (abort) begin
               state_n = IDLE;
               rem_n   = '0;
            end else begin
               {ser_n, data_n} = do_step(mode_q, data_q, ser_in, ser_q);
               rem_n = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         data_q <= '0;
         ser_q  <= 1'b0;
         mode_q <= '0;
         rem_q  <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_n;
         data_q <= data_n;
         ser_q  <= ser_n;
         mode_q <= mode_n;
         rem_q  <= rem_n;
         done_q <= done_n;
      end
   end

   assign data_out = data_q;
   assign ser_out  = ser_q;
   assign busy     = (state == SHIFT);
   assign done     = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register: arithmetic reference model compared
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_universal_shift_register;
   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic [2:0]       mode = '0;
   logic             load = 1'b0;
   logic [WIDTH-1:0] par_in = '0;
   logic             ser_in = 1'b0;
   logic             shift_en = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] count = '0;
   logic             abort = 1'b0;
   logic [WIDTH-1:0] data_out;
   logic             ser_out;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;
   int busy_cycles = 0;
   int done_pulses = 0;

   // Reference model state
   int m_data = 0;
   int m_ser = 0;
   int m_busy = 0;
   int m_done = 0;
   int m_rem = 0;
   int m_mode = 0;

   universal_shift_register #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n), .mode(mode), .load(load), .par_in(par_in),
      .ser_in(ser_in), .shift_en(shift_en), .start(start), .count(count), .abort(abort),
      .data_out(data_out), .ser_out(ser_out), .busy(busy), .done(done)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One step on an 8-bit value, described as plain arithmetic.
   task automatic model_step(input int m, input int s);
      int msb, lsb;
      msb = (m_data >> 7) & 1;
      lsb = m_data & 1;
      case (m)
         0: begin m_ser = msb; m_data = ((m_data * 2) + s) % 256; end
         1: begin m_ser = lsb; m_data = (m_data / 2) + s * 128; end
         2: begin m_ser = msb; m_data = ((m_data * 2) + msb) % 256; end
         3: begin m_ser = lsb; m_data = (m_data / 2) + lsb * 128; end
         4: begin m_ser = lsb; m_data = (m_data / 2) + msb * 128; end
         default: ;
      endcase
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_data = 0; m_ser = 0; m_busy = 0; m_done = 0; m_rem = 0; m_mode = 0;
      end else begin
         int nd;
         nd = 0;
         if (m_busy == 0) begin
            if (load) m_data = int'(par_in);
            else if (start) begin
               m_mode = int'(mode);
               if (count == 0) nd = 1;
               else begin m_busy = 1; m_rem = int'(count); end
            end else if (shift_en) model_step(int'(mode), int'(ser_in));
         end else if (abort) begin
            m_busy = 0; m_rem = 0;
         end else begin
            model_step(m_mode, int'(ser_in));
            m_rem = m_rem - 1;
            if (m_rem == 0) begin m_busy = 0; nd = 1; end
         end
         m_done = nd;
      end
   end

   // ---------------- scoreboard: compare every cycle ----------------
   always @(negedge clk) begin
      chk("data_out", int'(data_out), m_data);
      chk("ser_out", int'(ser_out), m_ser);
      chk("busy", int'(busy), m_busy);
      chk("done", int'(done), m_done);
      if (busy) busy_cycles++;
      if (done) done_pulses++;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [WIDTH-1:0] v);
      load = 1'b1; par_in = v;
      tick();
      load = 1'b0;
   endtask

   // Launch a burst, wait out busy (bounded), then one more cycle so done is counted.
   task automatic do_burst(input logic [2:0] m, input int n, input logic s);
      int b;
      mode = m; count = CNT_W'(n); ser_in = s; start = 1'b1;
      tick();
      start = 1'b0;
      b = 0;
      while (busy && b < 40) begin tick(); b++; end
      if (b >= 40) chk("burst_timeout", 1, 0);
      tick();
   endtask

   initial begin
      int bc0, dp0;
      #2 reset_n = 1'b0;
      #1;
      chk("reset_data", int'(data_out), 0);
      chk("reset_busy", int'(busy), 0);
      @(negedge clk) reset_n = 1'b1;
      tick();

      // SLL burst of 3 with ser_in = 1
      do_load(8'hA5);
      bc0 = busy_cycles; dp0 = done_pulses;
      do_burst(3'b000, 3, 1'b1);
      chk("sll3_data", int'(data_out), 'h2F);
      chk("sll3_ser", int'(ser_out), 1);
      chk("sll3_busy_cycles", busy_cycles - bc0, 3);
      chk("sll3_done_pulses", done_pulses - dp0, 1);

      // SRA, ROR full turn, ROL 1
      do_load(8'h96);
      do_burst(3'b100, 2, 1'b0);
      chk("sra2_data", int'(data_out), 'hE5);
      chk("sra2_ser", int'(ser_out), 1);
      do_load(8'h81);
      do_burst(3'b011, 8, 1'b0);
      chk("ror8_data", int'(data_out), 'h81);
      do_burst(3'b010, 1, 1'b0);
      chk("rol1_data", int'(data_out), 'h03);

      // Manual SRL steps
      dp0 = done_pulses;
      mode = 3'b001; shift_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ser_in = (i % 2 == 0);
         tick();
      end
      shift_en = 1'b0;
      tick();
      chk("srl_manual_data", int'(data_out), 'h55);
      chk("srl_manual_ser", int'(ser_out), 0);
      chk("srl_manual_no_done", done_pulses - dp0, 0);

      // Abort mid-burst, with load/shift_en ignored while busy
      do_load(8'h01);
      dp0 = done_pulses;
      mode = 3'b000; count = 4'd6; ser_in = 1'b0; start = 1'b1;
      tick();
      start = 1'b0; load = 1'b1; par_in = 8'hFF; shift_en = 1'b1;
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0; load = 1'b0; shift_en = 1'b0;
      chk("abort_data", int'(data_out), 'h04);
      chk("abort_busy", int'(busy), 0);
      tick();
      chk("abort_no_done", done_pulses - dp0, 0);

      // Zero-count start
      bc0 = busy_cycles; dp0 = done_pulses;
      mode = 3'b000; count = '0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("zero_done_high", int'(done), 1);
      chk("zero_busy_low", int'(busy), 0);
      tick();
      chk("zero_done_low", int'(done), 0);
      chk("zero_data", int'(data_out), 'h04);
      chk("zero_busy_cycles", busy_cycles - bc0, 0);
      chk("zero_done_pulses", done_pulses - dp0, 1);

      // Reserved mode burst
      bc0 = busy_cycles; dp0 = done_pulses;
      do_burst(3'b110, 4, 1'b1);
      chk("rsv_data", int'(data_out), 'h04);
      chk("rsv_busy_cycles", busy_cycles - bc0, 4);
      chk("rsv_done_pulses", done_pulses - dp0, 1);

      // Asynchronous reset in the middle of a burst
      do_load(8'hA5);
      mode = 3'b000; count = 4'd10; ser_in = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_data", int'(data_out), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_ser", int'(ser_out), 0);
      @(negedge clk) reset_n = 1'b1;
      tick();
      do_load(8'h3C);
      do_burst(3'b010, 4, 1'b0);
      chk("post_reset_rol4", int'(data_out), 'hC3);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         load     = ($urandom_range(0, 7) == 0);
         start    = ($urandom_range(0, 3) == 0);
         shift_en = $urandom_range(0, 1);
         abort    = ($urandom_range(0, 9) == 0);
         mode     = 3'($urandom_range(0, 7));
         count    = CNT_W'($urandom_range(0, 15));
         ser_in   = $urandom_range(0, 1);
         par_in   = WIDTH'($urandom);
         tick();
      end
      load = 1'b0; start = 1'b0; shift_en = 1'b0; abort = 1'b0;
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
